// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command framer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StOpc,
    StLen,
    StArg,
    StChk,
    StIssue,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxWait,
    TxReq,
    TxBusy
  } tx_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam int unsigned MAX_ARG_BYTES_DEFAULT = 4;

endpackage

// File: rtl/uart_resp_tx.sv
// Response-byte handshake with the UART transmitter: waits for the transmitter to be idle,
// raises tx_req until it goes busy, then reports done when it falls idle again.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] resp_byte,
  input  logic       tx_active,
  output logic [7:0] tx_byte,
  output logic       tx_req,
  output logic       done
);

  tx_state_e tx_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TxIdle;
      tx_byte  <= 8'h00;
      tx_req   <= 1'b0;
    end else begin
      unique case (tx_state)
        TxIdle: begin
          if (start) begin
            tx_byte <= resp_byte;
            if (tx_active) begin
              tx_state <= TxWait;
            end else begin
              tx_req   <= 1'b1;
              tx_state <= TxReq;
            end
          end
        end
        TxWait: begin
          if (!tx_active) begin
            tx_req   <= 1'b1;
            tx_state <= TxReq;
          end
        end
        TxReq: begin
          if (tx_active) begin
            tx_req   <= 1'b0;
            tx_state <= TxBusy;
          end
        end
        TxBusy: begin
          if (!tx_active) tx_state <= TxIdle;
        end
        default: tx_state <= TxIdle;
      endcase
    end
  end

  // Combinational so the framer leaves RESP in the same cycle the transmitter goes idle.
  assign done = (tx_state == TxBusy) && !tx_active;

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames UART bytes into commands (SYNC, OPC, LEN, ARG..., CHK) and answers with ACK/NAK.
// Optional inter-byte timeout enabled by defining UART_CMD_FRAMER_TIMEOUT_EN.
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_ARG_BYTES = MAX_ARG_BYTES_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned ARG_W = 8 * MAX_ARG_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_clear,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_opcode,
  output logic [ARG_W-1:0] cmd_arg,
  output logic [7:0]       tx_byte,
  output logic             tx_req,
  input  logic             tx_active
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_ARG_BYTES);

  state_e     state;
  logic [7:0] chk;
  logic [7:0] len;
  logic [7:0] idx;
  logic       accept;
  logic       timeout;
  logic       resp_start;
  logic [7:0] resp_byte;
  logic       resp_done;

  assign accept = rx_valid && !rx_clear &&
                  (state inside {StHunt, StOpc, StLen, StArg, StChk});

  always_comb begin
    resp_start = 1'b0;
    resp_byte  = NAK_BYTE;
    unique case (state)
      StLen:   resp_start = accept && (rx_data > MAX_LEN);
      StChk:   resp_start = accept && (rx_data != chk);
      StIssue: begin
        resp_start = cmd_ready;
        resp_byte  = ACK_BYTE;
      end
      default: ;
    endcase
  end

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        in_body;

  assign in_body = state inside {StOpc, StLen, StArg, StChk};
  assign timeout = in_body && !accept && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !in_body || accept || timeout) to_cnt <= 32'd0;
    else                                        to_cnt <= to_cnt + 32'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StHunt;
      rx_clear   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= 8'h00;
      cmd_arg    <= '0;
      chk        <= 8'h00;
      len        <= 8'h00;
      idx        <= 8'h00;
    end else begin
      rx_clear <= accept;
      if (timeout) begin
        state   <= StHunt;
        cmd_arg <= '0;
        chk     <= 8'h00;
        idx     <= 8'h00;
      end else begin
        unique case (state)
          StHunt: begin
            if (accept && rx_data == SYNC_BYTE) begin
              chk   <= 8'h00;
              state <= StOpc;
            end
          end
          StOpc: begin
            if (accept) begin
              cmd_opcode <= rx_data;
              chk        <= chk ^ rx_data;
              state      <= StLen;
            end
          end
          StLen: begin
            if (accept) begin
              len     <= rx_data;
              chk     <= chk ^ rx_data;
              cmd_arg <= '0;
              idx     <= 8'h00;
              if (resp_start)           state <= StResp;
              else if (rx_data == 8'h0) state <= StChk;
              else                      state <= StArg;
            end
          end
          StArg: begin
            if (accept) begin
              cmd_arg[8*idx +: 8] <= rx_data;
              chk                 <= chk ^ rx_data;
              idx                 <= idx + 8'd1;
              if (idx == len - 8'd1) state <= StChk;
            end
          end
          StChk: begin
            if (accept) begin
              if (resp_start) begin
                state <= StResp;
              end else begin
                cmd_valid <= 1'b1;
                state     <= StIssue;
              end
            end
          end
          StIssue: begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= StResp;
            end
          end
          StResp: begin
            if (resp_done) begin
              chk   <= 8'h00;
              idx   <= 8'h00;
              state <= StHunt;
            end
          end
          default: state <= StHunt;
        endcase
      end
    end
  end

  uart_resp_tx u_resp_tx (
    .clk       (clk),
    .reset     (reset),
    .start     (resp_start),
    .resp_byte (resp_byte),
    .tx_active (tx_active),
    .tx_byte   (tx_byte),
    .tx_req    (tx_req),
    .done      (resp_done)
  );

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed self-checking bench for uart_cmd_framer.
module tb_uart_cmd_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_clear;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_arg;
  logic [7:0]  tx_byte;
  logic        tx_req;
  logic        tx_active = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  uart_cmd_framer #(
    .MAX_ARG_BYTES  (4),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_clear   (rx_clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_arg    (cmd_arg),
    .tx_byte    (tx_byte),
    .tx_req     (tx_req),
    .tx_active  (tx_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rx_clear === 1'b1) got = 1'b1;
    end
    rx_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_byte %h: rx_clear stayed 0, required a pulse", b);
    end
  endtask

  // Sends n bytes of fr, most significant byte first.
  task automatic send_frame(input logic [63:0] fr, input int n);
    for (int i = 0; i < n; i++) send_byte(fr[8*(n-1-i) +: 8]);
  endtask

  // Response pending now: check it, then act as the UART transmitter.
  task automatic serve_tx(input logic [7:0] exp, input string name);
    n_checks++;
    if (tx_req !== 1'b1 || tx_byte !== exp) begin
      n_fail++;
      $display("FAIL %s resp: tx_req=%b tx_byte=%h, required 1 %h", name, tx_req, tx_byte, exp);
    end
    tx_active = 1'b1;
    tick();
    n_checks++;
    if (tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s req_drop: tx_req=%b, required 0", name, tx_req);
    end
    repeat (3) tick();
    tx_active = 1'b0;
    tick();
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] arg, input string name);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_opcode !== op || cmd_arg !== arg) begin
      n_fail++;
      $display("FAIL %s cmd: valid=%b op=%h arg=%h, required 1 %h %h",
               name, cmd_valid, cmd_opcode, cmd_arg, op, arg);
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cmd_drop: cmd_valid=%b, required 0", name, cmd_valid);
    end
    serve_tx(8'h06, name);
  endtask

  task automatic expect_nak_now(input string name);
    n_checks++;
    if (cmd_valid !== 1'b0 || tx_req !== 1'b1 || tx_byte !== 8'h15) begin
      n_fail++;
      $display("FAIL %s nak: valid=%b tx_req=%b tx_byte=%h, required 0 1 15",
               name, cmd_valid, tx_req, tx_byte);
    end
  endtask

  task automatic expect_quiet(input string name);
    n_checks++;
    if (cmd_valid !== 1'b0 || tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s quiet: valid=%b tx_req=%b, required 0 0", name, cmd_valid, tx_req);
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    n_checks++;
    if (rx_clear !== 1'b0 || cmd_valid !== 1'b0 || cmd_opcode !== 8'h00 ||
        cmd_arg !== 32'h0 || tx_byte !== 8'h00 || tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: clr=%b valid=%b op=%h arg=%h txb=%h req=%b, required all 0",
               name, rx_clear, cmd_valid, cmd_opcode, cmd_arg, tx_byte, tx_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    expect_reset_outputs("reset");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    send_frame(64'hA5_01_02_34_12_25, 6);
    expect_cmd(8'h01, 32'h0000_1234, "good_frame");
  endtask

  task automatic test_max_len();
    send_frame(64'hA5_10_04_01_02_03_04_10, 8);
    expect_cmd(8'h10, 32'h0403_0201, "max_len");
  endtask

  task automatic test_noise_len0();
    send_frame(64'h00_FF_37_A5_07_00_07, 7);
    expect_cmd(8'h07, 32'h0, "noise_len0");
  endtask

  task automatic test_bad_chk();
    send_frame(64'hA5_01_02_34_12_26, 6);
    expect_nak_now("bad_chk");
    serve_tx(8'h15, "bad_chk");
    send_frame(64'h01_02, 2);
    expect_quiet("bad_chk_hunt");
  endtask

  task automatic test_len_overflow();
    send_frame(64'hA5_01_05, 3);
    expect_nak_now("len_overflow");
    serve_tx(8'h15, "len_overflow");
    send_frame(64'h00_25, 2);
    expect_quiet("len_overflow_hunt");
  endtask

  task automatic test_stall();
    send_frame(64'hA5_01_02_34_12_25, 6);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (cmd_valid !== 1'b1 || cmd_opcode !== 8'h01 || cmd_arg !== 32'h1234 ||
          rx_clear !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid=%b op=%h arg=%h clr=%b, required 1 01 00001234 0",
                 i, cmd_valid, cmd_opcode, cmd_arg, rx_clear);
      end
    end
    rx_valid = 1'b0;
    expect_cmd(8'h01, 32'h0000_1234, "stall");
  endtask

  task automatic test_sync_in_body();
    send_frame(64'hA5_A5_01_A5_01, 5);
    expect_cmd(8'hA5, 32'h0000_00A5, "sync_in_body");
  endtask

  task automatic test_busy_on_resp();
    tx_active = 1'b1;
    send_frame(64'hA5_01_05, 3);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (tx_req !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_wait[%0d]: tx_req=%b, required 0", i, tx_req);
      end
      tick();
    end
    tx_active = 1'b0;
    tick();
    serve_tx(8'h15, "busy_on_resp");
  endtask

  task automatic test_back_to_back();
    send_frame(64'hA5_01_02_34_12_25, 6);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tx_active = 1'b1;
    tick();
    tick();
    // SYNC offered in the very cycle tx_active falls: must wait one cycle.
    tx_active = 1'b0;
    rx_data   = 8'hA5;
    rx_valid  = 1'b1;
    tick();
    n_checks++;
    if (rx_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_early: rx_clear=%b, required 0", rx_clear);
    end
    tick();
    n_checks++;
    if (rx_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: rx_clear=%b, required 1", rx_clear);
    end
    rx_valid = 1'b0;
    send_frame(64'h07_00_07, 3);
    expect_cmd(8'h07, 32'h0, "back_to_back");
  endtask

  task automatic test_reset_mid_arg();
    send_frame(64'hA5_01_02_34, 4);
    reset = 1'b1;
    tick();
    expect_reset_outputs("reset_mid_arg");
    reset = 1'b0;
    tick();
    send_frame(64'hA5_01_02_34_12_25, 6);
    expect_cmd(8'h01, 32'h0000_1234, "after_reset");
  endtask

`ifdef UART_CMD_FRAMER_TIMEOUT_EN
  task automatic test_timeout();
    bit seen = 1'b0;
    send_frame(64'hA5_01, 2);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_req !== 1'b0 || cmd_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL timeout_silent: response or command seen, required none");
    end
    send_frame(64'hA5_01_02_34_12_25, 6);
    expect_cmd(8'h01, 32'h0000_1234, "timeout_recover");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_good_frame();
    test_max_len();
    test_noise_len0();
    test_bad_chk();
    test_len_overflow();
    test_stall();
    test_sync_in_body();
    test_busy_on_resp();
    test_back_to_back();
`ifdef UART_CMD_FRAMER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_arg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
